// File: rtl/ls_pkg.sv
// Shared encodings for the 74LS194 serial frame transmitter: FSM states and receiver mode lines.
package ls_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SR   = 2'b01;
    localparam logic [1:0] MODE_SL   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    function automatic logic [1:0] shift_mode(input logic dir);
        return dir ? MODE_SL : MODE_SR;
    endfunction

endpackage

// File: rtl/ls_bit_counter.sv
// Bit-position counter for the SHIFT phase; saturates at WIDTH-1 and flags the final bit.
module ls_bit_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_term
);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_term) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_count = r_count;
    assign o_term  = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/ls194_frame_tx.sv
// Serial frame transmitter driving a 74LS194 receiver: clear pulse, WIDTH shift cycles, done pulse.
module ls194_frame_tx
    import ls_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    input  logic             DIR,
    input  logic             START,
    input  logic             ABORT,
    output logic             SR_OUT,
    output logic             SL_OUT,
    output logic             S1,
    output logic             S0,
    output logic             RCLR,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic             r_dir;
    logic             r_sr;
    logic             r_sl;
    logic [1:0]       r_mode;
    logic             r_rclr;
    logic             r_busy;
    logic             r_done;

    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_idx;
    logic [CW-1:0]    w_idx_rev;
    logic             w_term;
    logic             w_clr;
    logic             w_en;
    logic             w_bit;
    logic             w_accept;

    ls_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .i_clk   (CLK),
        .i_rst_n (CLR),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_count (w_count),
        .o_term  (w_term)
    );

    assign w_clr    = (r_state != ST_SHIFT);
    assign w_en     = (r_state == ST_SHIFT) && !ABORT;
    assign w_accept = START && !ABORT;

    // Outputs are registered, so select the bit for the cycle being entered, not the current one.
    assign w_idx     = (r_state == ST_SHIFT) ? w_count + CW'(1) : '0;
    assign w_idx_rev = CW'(WIDTH - 1) - w_idx;
    assign w_bit     = r_dir ? r_sh[w_idx_rev] : r_sh[w_idx];

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= ST_IDLE;
            r_sh    <= '0;
            r_dir   <= 1'b0;
            r_sr    <= 1'b0;
            r_sl    <= 1'b0;
            r_mode  <= MODE_HOLD;
            r_rclr  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_sr   <= 1'b0;
            r_sl   <= 1'b0;
            r_mode <= MODE_HOLD;
            r_rclr <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_sh    <= D;
                        r_dir   <= DIR;
                        r_state <= ST_CLEAR;
                        r_rclr  <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLEAR, ST_SHIFT: begin
                    if (ABORT) begin
                        r_state <= ST_IDLE;
                    end else if (r_state == ST_SHIFT && w_term) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_SHIFT;
                        r_busy  <= 1'b1;
                        r_mode  <= shift_mode(r_dir);
                        r_sr    <= !r_dir && w_bit;
                        r_sl    <= r_dir && w_bit;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign SR_OUT = r_sr;
    assign SL_OUT = r_sl;
    assign S1     = r_mode[1];
    assign S0     = r_mode[0];
    assign RCLR   = r_rclr;
    assign BUSY   = r_busy;
    assign DONE   = r_done;

endmodule

// File: tb/tb_ls194_frame_tx.sv
// Randomized scoreboard bench: transmitter feeding a behavioural 74LS194 receiver on the same clock.
module tb_ls194_frame_tx;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         CLR = 1'b0;
    logic [W-1:0] D = '0;
    logic         DIR = 1'b0;
    logic         START = 1'b0;
    logic         ABORT = 1'b0;
    logic         SR_OUT, SL_OUT, S1, S0, RCLR, BUSY, DONE;

    always #5 CLK = ~CLK;

    ls194_frame_tx #(
        .WIDTH (W)
    ) dut (
        .CLK    (CLK),
        .CLR    (CLR),
        .D      (D),
        .DIR    (DIR),
        .START  (START),
        .ABORT  (ABORT),
        .SR_OUT (SR_OUT),
        .SL_OUT (SL_OUT),
        .S1     (S1),
        .S0     (S0),
        .RCLR   (RCLR),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    // Receiver: rq[W-1] is QA, rq[0] is QD.
    logic [W-1:0] rq = 4'b0101;
    always @(posedge CLK or negedge RCLR) begin
        if (!RCLR) rq <= '0;
        else begin
            case ({S1, S0})
                2'b01:   rq <= {SR_OUT, rq[W-1:1]};
                2'b10:   rq <= {rq[W-2:0], SL_OUT};
                default: rq <= rq;
            endcase
        end
    end

    int           checks = 0;
    int           failures = 0;
    int           frames_done = 0;
    int           mp = 0;
    logic [W-1:0] m_d = '0;
    logic         m_dir = 1'b0;
    logic [W-1:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] outvec();
        return {BUSY, DONE, RCLR, S1, S0, SR_OUT, SL_OUT};
    endfunction

    // Frame phase p: 0 idle, 1 clear, 2..W+1 bit p-2, W+2 done.
    function automatic logic [6:0] exp_out(input int p, input logic [W-1:0] d, input logic dr);
        logic       sh, busy, done, rclr, sr, sl;
        logic [1:0] mode;
        int         k;
        sh   = (p >= 2) && (p <= W + 1);
        k    = sh ? p - 2 : 0;
        busy = (p >= 1) && (p <= W + 1);
        done = (p == W + 2);
        rclr = (p != 1);
        mode = sh ? (dr ? 2'b10 : 2'b01) : 2'b00;
        sr   = sh && !dr && d[k];
        sl   = sh && dr && d[W-1-k];
        return {busy, done, rclr, mode, sr, sl};
    endfunction

    // Reference model: advances the frame phase on each rising edge.
    initial forever begin
        @(posedge CLK);
        if (!CLR) begin
            mp = 0;
        end else if (mp == 0 || mp == W + 2) begin
            if (START && !ABORT) begin
                mp    = 1;
                m_d   = D;
                m_dir = DIR;
                sb_q.push_back(D);
            end else begin
                mp = 0;
            end
        end else if (ABORT) begin
            mp = 0;
            void'(sb_q.pop_back());
        end else begin
            mp++;
        end
    end

    // Monitor: per-cycle output check plus receiver word on every DONE pulse.
    initial forever begin
        @(negedge CLK);
        check("outputs", 32'(outvec()), 32'(exp_out(mp, m_d, m_dir)));
        if (DONE) begin
            frames_done++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got DONE expected no frame at %0t", $time);
            end else begin
                check("rx_word", 32'(rq), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send(input logic [W-1:0] d, input logic dr);
        @(negedge CLK);
        D = d; DIR = dr; START = 1'b1;
        @(negedge CLK);
        START = 1'b0; D = W'($urandom); DIR = 1'($urandom);
        cyc(W + 2);
    endtask

    int f0;

    initial begin
        cyc(3);
        check("reset_out", 32'(outvec()), 32'(7'b0010000));
        CLR = 1'b1;
        cyc(2);

        send(4'b1010, 1'b0);
        check("rx_1010", 32'(rq), 32'(4'b1010));
        send(4'b1101, 1'b1);
        check("rx_1101", 32'(rq), 32'(4'b1101));

        f0 = frames_done;
        @(negedge CLK);
        D = 4'b0110; DIR = 1'b0; START = 1'b1;
        @(negedge CLK);
        D = 4'b1001;
        cyc(11);
        START = 1'b0;
        cyc(W + 3);
        check("b2b_frames", 32'(frames_done - f0), 32'd2);
        check("rx_1001", 32'(rq), 32'(4'b1001));

        f0 = frames_done;
        @(negedge CLK);
        D = W'($urandom); DIR = 1'($urandom); START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("abort_idle", 32'({BUSY, S1, S0, RCLR}), 32'(4'b0001));
        ABORT = 1'b1; START = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0; START = 1'b0;
        check("abort_start", 32'({BUSY, RCLR}), 32'(2'b01));
        cyc(W + 3);
        check("abort_no_done", 32'(frames_done - f0), 32'd0);

        @(negedge CLK);
        D = 4'b0111; DIR = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        cyc(2);
        #2 CLR = 1'b0;
        mp = 0;
        sb_q.delete();
        #1 check("async_reset", 32'(outvec()), 32'(7'b0010000));
        @(negedge CLK);
        CLR = 1'b1;
        cyc(1);
        send(4'b0011, 1'b1);
        check("rx_after_reset", 32'(rq), 32'(4'b0011));

        repeat (400) begin
            @(negedge CLK);
            D     = W'($urandom);
            DIR   = 1'($urandom);
            START = ($urandom_range(0, 2) == 0);
            ABORT = ($urandom_range(0, 15) == 0);
        end
        @(negedge CLK);
        START = 1'b0; ABORT = 1'b0;
        cyc(W + 4);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
